// File: rtl/adp_pkg.sv
// adp_pkg: definitions shared by the upstream and downstream GEP AXI-stream
// adaptors.
//   adp_state_t  - event sequencing states
//   AXIS_DW      - AXI-stream data width
//   HDR_TID_LSB, HDR_TID_W - position of the BCID field in the event header
//   hdr_bcid()   - extracts the BCID from a header word
//   hdr_count()  - extracts the data-word count from a header word
package adp_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_HDR_RD,
      ST_HDR_CAP,
      ST_STREAM,
      ST_DONE
   } adp_state_t;

   localparam int unsigned AXIS_DW      = 128;
   localparam int unsigned HDR_TID_LSB  = 10;
   localparam int unsigned HDR_TID_W    = 11;
   // Widest count field that can sit below the BCID field.
   localparam int unsigned HDR_CNT_MAXW = 10;

   function automatic logic [HDR_TID_W-1:0] hdr_bcid(input logic [AXIS_DW-1:0] hdr);
      return hdr[HDR_TID_LSB +: HDR_TID_W];
   endfunction

   // Count field is the low 'aw' bits; higher bits of the result are zero.
   function automatic logic [HDR_CNT_MAXW-1:0] hdr_count(input logic [AXIS_DW-1:0] hdr,
                                                        input int unsigned       aw);
      logic [HDR_CNT_MAXW-1:0] cnt;
      cnt = '0;
      for (int unsigned i = 0; i < HDR_CNT_MAXW; i++) begin
         if (i < aw) cnt[i] = hdr[i];
      end
      return cnt;
   endfunction

endpackage

// File: rtl/adp_fifo2.sv
// adp_fifo2: 2-entry register FIFO, first-word-fall-through (dout is the head
// entry whenever empty=0). A push and a pop in the same cycle are both
// honoured; a push into a full FIFO is accepted only together with a pop.
//   clk, rst_n  - clock, synchronous active-low reset (flushes the FIFO)
//   push, din   - write request and data
//   pop         - read request (ignored while empty)
//   dout        - head entry
//   full, empty, occ - status and occupancy (0..2)
module adp_fifo2 #(
   parameter int unsigned W = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty,
   output logic [1:0]   occ
);

   logic [W-1:0] mem0_q, mem1_q;
   logic [1:0]   occ_q;
   logic         do_push, do_pop;

   assign empty   = (occ_q == 2'd0);
   assign full    = (occ_q == 2'd2);
   assign occ     = occ_q;
   assign dout    = mem0_q;
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem0_q <= '0;
         mem1_q <= '0;
         occ_q  <= 2'd0;
      end else begin
         case ({do_push, do_pop})
            2'b10: begin
               if (occ_q == 2'd0) mem0_q <= din;
               else               mem1_q <= din;
               occ_q <= occ_q + 2'd1;
            end
            2'b01: begin
               mem0_q <= mem1_q;
               occ_q  <= occ_q - 2'd1;
            end
            2'b11: begin
               if (occ_q == 2'd1) begin
                  mem0_q <= din;
               end else begin
                  mem0_q <= mem1_q;
                  mem1_q <= din;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/upstream_adp.sv
// upstream_adp: reads a completed GEP event buffer through the memory read
// port (1-cycle latency) and streams payload words 1..N as AXI-stream beats,
// TID = header BCID, TLAST on word N, then pulses rd_EvTID_DONE.
//   clk, ARESETn          - clock, synchronous active-low reset
//   ev_rdy                - event buffer complete and readable
//   rd_en, rd_addr, rd_data - memory read port
//   rd_EvTID_DONE         - one-cycle pulse, buffer consumed
//   hdr_err               - one-cycle pulse, header rejected
//   TVALID..TID           - AXI-stream master
// Optional feature: UPSTREAM_ADP_HDR_CHECK_EN rejects headers with N==0 or
// BCID==0; when undefined hdr_err is tied low and the header is trusted.
module upstream_adp
   import adp_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 10
) (
   input  logic                  clk,
   input  logic                  ARESETn,
   input  logic                  ev_rdy,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic [AXIS_DW-1:0]    rd_data,
   output logic                  rd_EvTID_DONE,
   output logic                  hdr_err,
   output logic                  TVALID,
   input  logic                  TREADY,
   output logic [AXIS_DW-1:0]    TDATA,
   output logic [15:0]           TSTRB,
   output logic [15:0]           TKEEP,
   output logic                  TLAST,
   output logic [HDR_TID_W-1:0]  TID
);

   localparam logic [ADDR_WIDTH:0] ADDR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

   adp_state_t               state_q, state_d;
   logic [ADDR_WIDTH:0]      addr_q, n_q, n_cur, n_hdr;
   logic [HDR_CNT_MAXW-1:0]  cnt_raw;
   logic [HDR_TID_W-1:0]     bcid_hdr, tid_q;
   logic                     pend_q, pend_last_q, done_q;
   logic                     issue, credit, pop, last_hs, hdr_bad;
   logic                     fifo_full, fifo_empty;
   logic [1:0]               fifo_occ;
   logic [AXIS_DW:0]         fifo_dout;

   assign cnt_raw  = hdr_count(rd_data, ADDR_WIDTH);
   assign n_hdr    = {1'b0, cnt_raw[ADDR_WIDTH-1:0]};
   assign bcid_hdr = hdr_bcid(rd_data);
   // In HDR_CAP the count is taken straight from rd_data so the first payload
   // read can go out in the same cycle the header is registered.
   assign n_cur    = (state_q == ST_HDR_CAP) ? n_hdr : n_q;

`ifdef UPSTREAM_ADP_HDR_CHECK_EN
   assign hdr_bad = (n_hdr == '0) || (bcid_hdr == '0);
`else
   assign hdr_bad = 1'b0;
`endif

   assign TVALID  = ~fifo_empty;
   assign pop     = TVALID & TREADY;
   assign last_hs = pop & fifo_dout[0];

   // Read credit: occupancy + in-flight < 2, with the word leaving this cycle
   // already subtracted so a continuously ready sink sees no bubbles.
   assign credit = pend_q ? (fifo_empty | ((fifo_occ == 2'd1) & pop))
                          : (~fifo_full | pop);

   always_comb begin
      state_d = state_q;
      issue   = 1'b0;
      case (state_q)
         ST_IDLE:    if (ev_rdy) state_d = ST_HDR_RD;
         ST_HDR_RD:  state_d = ST_HDR_CAP;
         ST_HDR_CAP: begin
            if (hdr_bad) begin
               state_d = ST_DONE;
            end else begin
               issue   = credit && (addr_q <= n_cur);
               state_d = ST_STREAM;
            end
         end
         ST_STREAM: begin
            issue = credit && (addr_q <= n_cur);
            if (last_hs) state_d = ST_DONE;
         end
         ST_DONE:    if (!ev_rdy) state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   assign rd_en   = issue | (state_q == ST_HDR_RD);
   assign rd_addr = issue ? addr_q[ADDR_WIDTH-1:0] : '0;

   always_ff @(posedge clk) begin
      if (!ARESETn) begin
         state_q     <= ST_IDLE;
         addr_q      <= '0;
         n_q         <= '0;
         tid_q       <= '0;
         pend_q      <= 1'b0;
         pend_last_q <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         pend_q      <= issue;
         pend_last_q <= issue && (addr_q == n_cur);
         done_q      <= ((state_q == ST_STREAM) && last_hs) ||
                        ((state_q == ST_HDR_CAP) && hdr_bad);
         if (state_q == ST_HDR_RD) addr_q <= ADDR_ONE;
         else if (issue)           addr_q <= addr_q + ADDR_ONE;
         if (state_q == ST_HDR_CAP) begin
            n_q   <= n_hdr;
            tid_q <= bcid_hdr;
         end
      end
   end

`ifdef UPSTREAM_ADP_HDR_CHECK_EN
   logic err_q;
   always_ff @(posedge clk) begin
      if (!ARESETn) err_q <= 1'b0;
      else          err_q <= (state_q == ST_HDR_CAP) && hdr_bad;
   end
   assign hdr_err = err_q;
`else
   assign hdr_err = 1'b0;
`endif

   adp_fifo2 #(
      .W(AXIS_DW + 1)
   ) u_fifo (
      .clk   (clk),
      .rst_n (ARESETn),
      .push  (pend_q),
      .din   ({rd_data, pend_last_q}),
      .pop   (pop),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty),
      .occ   (fifo_occ)
   );

   assign TDATA         = fifo_dout[AXIS_DW:1];
   assign TLAST         = fifo_dout[0];
   assign TID           = tid_q;
   assign TSTRB         = '1;
   assign TKEEP         = '1;
   assign rd_EvTID_DONE = done_q;

endmodule

// File: tb/tb_upstream_adp.sv
module tb_upstream_adp;
   import adp_pkg::*;

   localparam int unsigned AW = 10;

   logic          clk = 1'b0;
   logic          ARESETn = 1'b0;
   logic          ev_rdy = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic [127:0]  rd_data = '0;
   logic          rd_EvTID_DONE, hdr_err;
   logic          TVALID, TLAST;
   logic          TREADY = 1'b1;
   logic [127:0]  TDATA;
   logic [15:0]   TSTRB, TKEEP;
   logic [10:0]   TID;

   always #5 clk = ~clk;

   upstream_adp #(.ADDR_WIDTH(AW)) dut (
      .clk           (clk),
      .ARESETn       (ARESETn),
      .ev_rdy        (ev_rdy),
      .rd_en         (rd_en),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .rd_EvTID_DONE (rd_EvTID_DONE),
      .hdr_err       (hdr_err),
      .TVALID        (TVALID),
      .TREADY        (TREADY),
      .TDATA         (TDATA),
      .TSTRB         (TSTRB),
      .TKEEP         (TKEEP),
      .TLAST         (TLAST),
      .TID           (TID)
   );

   int unsigned tests = 0, fails = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [127:0] data;
      logic         last;
      logic [10:0]  tid;
   } beat_t;

   beat_t        exp_q[$];
   logic [127:0] mem [0:1023];

   int unsigned cyc = 0;
   int unsigned ev_reads = 0;
   int unsigned cur_n = 0;
   int unsigned beats_seen = 0;
   int unsigned done_cnt = 0;
   int unsigned err_cnt = 0;
   int          first_valid_cyc = -1;
   int          last_beat_cyc = -1;
   int          done_cyc = -1;
   int unsigned ready_mode = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Memory: data for a read appears one cycle later.
   always @(posedge clk) if (rd_en) rd_data <= mem[rd_addr];

   // Read-port checker: reads of an event must be 0,1,2,... never above N,
   // with at most two payload words issued but not yet handed off.
   always @(posedge clk) begin
      if (ARESETn && rd_en) begin
         check("rd_addr_order", rd_addr, ev_reads);
         check("rd_addr_le_n", ev_reads <= cur_n, 1);
         if (ev_reads > 0) check("outstanding_le2", (ev_reads - beats_seen) <= 2, 1);
         ev_reads++;
      end
   end

   // Scoreboard monitor, sampled on the falling edge.
   logic  stalled = 1'b0;
   beat_t held;
   always @(negedge clk) begin
      if (!ARESETn) begin
         stalled = 1'b0;
      end else begin
         if (stalled) begin
            check("hold_tvalid", TVALID, 1);
            check("hold_tdata", TDATA, held.data);
            check("hold_tlast", TLAST, held.last);
            check("hold_tid", TID, held.tid);
         end
         stalled = 1'b0;
         if (TVALID) begin
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
            if (TREADY) begin
               if (exp_q.size() == 0) begin
                  check("beat_expected", exp_q.size(), 1);
               end else begin
                  beat_t e;
                  e = exp_q.pop_front();
                  check("tdata", TDATA, e.data);
                  check("tlast", TLAST, e.last);
                  check("tid", TID, e.tid);
               end
               beats_seen++;
               last_beat_cyc = cyc;
            end else begin
               stalled   = 1'b1;
               held.data = TDATA;
               held.last = TLAST;
               held.tid  = TID;
            end
         end
         if (rd_EvTID_DONE) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (hdr_err) begin
            err_cnt++;
`ifdef UPSTREAM_ADP_HDR_CHECK_EN
            check("hdr_err_with_done", rd_EvTID_DONE, 1);
`else
            check("hdr_err_tied_low", hdr_err, 0);
`endif
         end
      end
   end

   // TREADY pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random,
   // 3 = driven by the stimulus.
   int unsigned rcnt = 0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0: TREADY = 1'b1;
            1: begin TREADY = ((rcnt % 3) == 0); rcnt++; end
            2: TREADY = 1'($urandom_range(0, 1));
            default: ;
         endcase
      end
   end

   int unsigned start_cyc;
   int unsigned done_base;

   task automatic start_event(input int unsigned n, input logic [10:0] bcid,
                              input int unsigned mode, input bit reject);
      logic [127:0] hdr;
      hdr = {$urandom, $urandom, $urandom, $urandom};
      hdr[9:0]   = n[9:0];
      hdr[20:10] = bcid;
      mem[0] = hdr;
      for (int unsigned i = 1; i <= n; i++) begin
         beat_t b;
         mem[i] = {$urandom, $urandom, $urandom, $urandom};
         b.data = mem[i];
         b.last = (i == n);
         b.tid  = bcid;
         if (!reject) exp_q.push_back(b);
      end
      cur_n           = reject ? 0 : n;
      ev_reads        = 0;
      beats_seen      = 0;
      first_valid_cyc = -1;
      last_beat_cyc   = -1;
      done_cyc        = -1;
      rcnt            = 0;
      ready_mode      = mode;
      done_base       = done_cnt;
      @(posedge clk);
      #1;
      start_cyc = cyc;
      ev_rdy    = 1'b1;
   endtask

   task automatic finish_event(input int unsigned n_beats);
      int unsigned budget;
      budget = 4 * n_beats + 60;
      for (int unsigned k = 0; k < budget; k++) begin
         @(posedge clk);
         #1;
         if (done_cnt != done_base) break;
      end
      check("done_seen", done_cnt != done_base, 1);
      ev_rdy = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("done_pulse_count", done_cnt - done_base, 1);
      check("queue_drained", exp_q.size(), 0);
      check("beats_streamed", beats_seen, n_beats);
      check("reads_issued", ev_reads, n_beats + 1);
      exp_q.delete();
   endtask

   initial begin
      int unsigned n;
      for (int unsigned i = 0; i < 1024; i++) mem[i] = '0;

      // Reset values.
      repeat (3) @(posedge clk);
      #1;
      check("rst_tvalid", TVALID, 0);
      check("rst_rd_en", rd_en, 0);
      check("rst_rd_addr", rd_addr, 0);
      check("rst_done", rd_EvTID_DONE, 0);
      check("rst_hdr_err", hdr_err, 0);
      check("rst_tlast", TLAST, 0);
      check("rst_tid", TID, 0);
      check("rst_tdata", TDATA, 0);
      check("tstrb_ones", TSTRB, 16'hFFFF);
      check("tkeep_ones", TKEEP, 16'hFFFF);
      ARESETn = 1'b1;
      repeat (2) @(posedge clk);

      // N=3, exact latency with a always-ready sink.
      start_event(3, 11'h05A, 0, 1'b0);
      finish_event(3);
      check("t_first_valid", first_valid_cyc, start_cyc + 4);
      check("t_last_beat", last_beat_cyc, start_cyc + 6);
      check("t_done", done_cyc, start_cyc + 7);

      // N=4 with a stalling sink.
      start_event(4, 11'h3C1, 1, 1'b0);
      finish_event(4);

      // N=1: single beat, one payload read.
      start_event(1, 11'h001, 0, 1'b0);
      finish_event(1);
      check("n1_single_beat_cycle", last_beat_cyc, first_valid_cyc);

      // N at the top of the address range, no bubbles.
      start_event(1023, 11'h7FF, 0, 1'b0);
      finish_event(1023);
      check("full_range_no_bubble", last_beat_cyc - first_valid_cyc, 1022);

      // Reset while beat 2 of an 8-word event is on the bus.
      start_event(8, 11'h155, 0, 1'b0);
      for (int unsigned k = 0; k < 40; k++) begin
         @(posedge clk);
         #1;
         if (beats_seen >= 1) break;
      end
      check("mid_rst_beat1_seen", beats_seen >= 1, 1);
      ready_mode = 3;
      TREADY     = 1'b0;
      ARESETn    = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      check("mid_rst_tvalid", TVALID, 0);
      check("mid_rst_rd_en", rd_en, 0);
      ARESETn    = 1'b1;
      ev_rdy     = 1'b0;
      ready_mode = 0;
      repeat (5) @(posedge clk);
      #1;
      check("mid_rst_no_done", done_cnt - done_base, 0);

      // Following event restarts from address 1.
      start_event(5, 11'h0A7, 0, 1'b0);
      finish_event(5);

      // Randomized events with a random sink.
      for (int unsigned e = 0; e < 12; e++) begin
         n = $urandom_range(1, 40);
         start_event(n, 11'($urandom_range(1, 2047)), 2, 1'b0);
         finish_event(n);
      end

`ifdef UPSTREAM_ADP_HDR_CHECK_EN
      // Rejected headers: N==0, then BCID==0.
      for (int unsigned r = 0; r < 2; r++) begin
         int unsigned eb;
         eb = err_cnt;
         start_event((r == 0) ? 0 : 6, (r == 0) ? 11'h005 : 11'h000, 0, 1'b1);
         finish_event(0);
         check("reject_no_valid", first_valid_cyc, -1);
         check("reject_err_pulse", err_cnt - eb, 1);
      end
`else
      check("hdr_err_never", err_cnt, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/upstream_adp.md
# upstream_adp

AXI-stream source adaptor that reads a completed GEP event buffer through the legacy memory read port and streams it as 128-bit AXI-stream beats to the AXI downstream adaptor.
- Buffer word 0 is the event header: data-word count N in bits [ADDR_WIDTH-1:0], BCID in bits [20:10].
- Words 1..N are payload.
- The block emits words 1..N in order with TID = BCID and TLAST on word N, then releases the buffer with a one-cycle done pulse.

## Interface
Parameters:
- ADDR_WIDTH, 10, buffer address width; legal range 2..10, so the count field never overlaps the BCID field.

Ports:
- clk  in  1  sole clock; all logic on the rising edge.
- ARESETn  in  1  reset, synchronous, active-low.
- ev_rdy  in  1  level; an event buffer is complete and readable.
- rd_en  out  1  memory read strobe; data returns exactly 1 cycle later.
- rd_addr  out  ADDR_WIDTH  read address.
- rd_data  in  128  read data for the read issued in the previous cycle.
- rd_EvTID_DONE  out  1  one-cycle pulse; the buffer is consumed.
- hdr_err  out  1  one-cycle pulse on a rejected header.
- TVALID  out  1  AXI-stream valid.
- TREADY  in  1  AXI-stream ready.
- TDATA  out  128  payload word.
- TSTRB, TKEEP  out  16 each  constant all-ones.
- TLAST  out  1  high on payload word N.
- TID  out  11  header BCID, constant for the whole event.

## Operation
- **Reset values** (while ARESETn=0 at a clock edge):
  - State IDLE.
  - rd_en=0, rd_addr=0, rd_EvTID_DONE=0, hdr_err=0.
  - TVALID=0, TLAST=0, TID=0, TDATA=0.
  - FIFO empty, counters cleared.
- **States:**
  - IDLE: wait for ev_rdy=1, then go to HDR_RD.
  - HDR_RD: rd_en=1, rd_addr=0; go to HDR_CAP.
  - HDR_CAP: register N and BCID from rd_data; go to STREAM.
  - STREAM: issue payload reads and drain the FIFO; go to DONE after the handshake of the TLAST beat.
  - DONE: pulse rd_EvTID_DONE on the entry cycle only, then hold until ev_rdy=0; go to IDLE.
- **Read issue in STREAM (and in HDR_CAP):**
  - rd_addr starts at 1 and increments after each issued read.
  - A read is issued only when (FIFO occupancy + reads in flight) < 2 and rd_addr ≤ N.
  - No read is ever issued to an address above N.
- **Output FIFO:**
  - 2 entries, registered; every returned word is written into it.
  - Each entry carries {TDATA, TLAST}; TLAST = (address == N).
  - TVALID = FIFO not empty.
  - An entry pops on TVALID&TREADY.
  - A push and a pop in the same cycle are both honoured.
  - The FIFO never overflows, guaranteed by the credit rule above.
- **AXI-stream rules:**
  - Once TVALID=1, TDATA, TLAST and TID hold until TREADY=1.
  - TVALID never drops without a handshake.
  - TREADY has no combinational path to TVALID.
- **Arithmetic:**
  - Address counter is ADDR_WIDTH+1 bits, so the compare at N = 2^ADDR_WIDTH−1 does not wrap.
  - Beats streamed = N exactly.
- **Reset mid-event:** return to IDLE on the next edge. The in-flight read is discarded, the FIFO is flushed, and no done pulse is emitted.

## Timing
- ev_rdy sampled high at edge c: HDR_RD during c+1, header captured at end of c+2, read of address 1 issued in c+2.
- First TVALID=1 in cycle c+4.
- With TREADY held at 1: one beat per cycle after the first beat, no bubbles.
- Final beat handshake in cycle t: rd_EvTID_DONE=1 in cycle t+1.
- Minimum event-to-event turnaround: ev_rdy low for one cycle after DONE.

## Configuration
- UPSTREAM_ADP_HDR_CHECK_EN defined:
  - In HDR_CAP, a header with N==0 or BCID==0 is rejected.
  - No reads are issued and no beats are streamed.
  - hdr_err and rd_EvTID_DONE pulse together in the next cycle, via DONE.
  - This matters because the consumer ignores TID==0.
- UPSTREAM_ADP_HDR_CHECK_EN undefined:
  - hdr_err is tied to 0 and the header is trusted.
  - N==0 and BCID==0 are illegal inputs; behaviour is unspecified and not tested.

## Structure
- Package adp_pkg holds:
  - State enum.
  - AXIS_DW=128.
  - HDR_TID_LSB=10, HDR_TID_W=11.
  - Header field extraction helpers.
  - Shared by the upstream and downstream adaptors.
- Sub-module adp_fifo2: 2-entry register FIFO with push/pop/full/empty/occupancy, parameterised width.

## Test plan
- Header N=3, BCID=0x05A, TREADY=1 → beats addr1..3 on cycles c+4..c+6; TLAST only on the third; TID=0x05A; done pulse at c+7.
- N=4, TREADY toggling 1,0,0,1,... → no beat lost or duplicated, TDATA stable while stalled, at most 2 reads outstanding.
- N=1 → single beat with TLAST=1; exactly one payload read to address 1.
- N=2^ADDR_WIDTH−1, TREADY=1 → all 1023 beats; no read to address 0 or ≥1024.
- Reset asserted during beat 2 of N=8 → TVALID=0 next cycle, no done pulse; next event streams from address 1.
- With the macro defined, header N=0 or BCID=0 → no TVALID; hdr_err=rd_EvTID_DONE=1 for one cycle.
